// File: rtl/if_fetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and the instruction memory (slave).
// The protocol is a request strobe with an address, answered later by a response strobe with data.
interface if_fetch_unit_if #(
    parameter int N = 32
);
    logic         imem_req;
    logic [N-1:0] imem_addr;
    logic         imem_rvalid;
    logic [N-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, keeps a single imem request outstanding, and
// buffers returned words (plus one skid entry) for the IF/ID register, dropping wrong-path fetches.
module if_fetch_unit #(
    parameter int           N        = 32,
    parameter logic [N-1:0] RESET_PC = '0,
    parameter int           PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            freeze,
    input  logic            redirect_valid,
    input  logic [N-1:0]    redirect_pc,
    if_fetch_unit_if.master imem,
    output logic [N-1:0]    pc_o,
    output logic [N-1:0]    instr_o,
    output logic            flush_o
);

    localparam logic [N-1:0] STEP = N'(PC_STEP);

    typedef enum logic [1:0] {
        S_ISSUE,
        S_WAIT,
        S_FULL,
        S_DROP
    } state_e;

    state_e       state_q,      state_d;
    logic [N-1:0] pc_q,         pc_d;
    logic         buf_valid_q,  buf_valid_d;
    logic [N-1:0] buf_pc_q,     buf_pc_d;
    logic [N-1:0] buf_instr_q,  buf_instr_d;
    logic         skid_valid_q, skid_valid_d;
    logic [N-1:0] skid_pc_q,    skid_pc_d;
    logic [N-1:0] skid_instr_q, skid_instr_d;

    logic issue_req;
    logic consume;

    // IF/ID takes the buffered word on any edge where it is valid and neither held nor squashed.
    assign consume = buf_valid_q & ~freeze & ~redirect_valid;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
        if (!rstn) begin
            state_q      <= S_ISSUE;
            pc_q         <= RESET_PC;
            buf_valid_q  <= 1'b0;
            buf_pc_q     <= '0;
            buf_instr_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            buf_valid_q  <= buf_valid_d;
            buf_pc_q     <= buf_pc_d;
            buf_instr_q  <= buf_instr_d;
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d      = state_q;
        pc_d         = pc_q;
        buf_valid_d  = buf_valid_q;
        buf_pc_d     = buf_pc_q;
        buf_instr_d  = buf_instr_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        issue_req    = 1'b0;

        if (consume) begin
            buf_valid_d = 1'b0;
        end

        if (redirect_valid) begin
            pc_d         = redirect_pc;
            buf_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
            // A request still in flight must drain through DROP; otherwise restart at the target.
            if ((state_q == S_WAIT || state_q == S_DROP) && !imem.imem_rvalid) begin
                state_d = S_DROP;
            end else begin
                state_d = S_ISSUE;
            end
        end else begin
            unique case (state_q)
                S_ISSUE: begin
                    issue_req = 1'b1;
                    state_d   = S_WAIT;
                end
                S_WAIT: begin
                    if (imem.imem_rvalid) begin
                        pc_d = pc_q + STEP;
                        if (!buf_valid_q || consume) begin
                            buf_pc_d    = pc_q;
                            buf_instr_d = imem.imem_rdata;
                            buf_valid_d = 1'b1;
                            state_d     = S_ISSUE;
                        end else begin
                            skid_pc_d    = pc_q;
                            skid_instr_d = imem.imem_rdata;
                            skid_valid_d = 1'b1;
                            state_d      = S_FULL;
                        end
                    end
                end
                S_FULL: begin
                    if (!freeze) begin
                        buf_pc_d     = skid_pc_q;
                        buf_instr_d  = skid_instr_q;
                        buf_valid_d  = skid_valid_q;
                        skid_valid_d = 1'b0;
                        state_d      = S_ISSUE;
                    end
                end
                S_DROP: begin
                    if (imem.imem_rvalid) begin
                        state_d = S_ISSUE;
                    end
                end
                default: begin
                    state_d = S_ISSUE;
                end
            endcase
        end
    end

    // A redirect in ISSUE suppresses the wrong-path request so the target issues next cycle
    // without ever having two requests in flight.
    assign imem.imem_req  = issue_req & rstn;
    assign imem.imem_addr = pc_q;

    assign pc_o    = buf_pc_q;
    assign instr_o = buf_instr_q;
    assign flush_o = ~buf_valid_q | redirect_valid;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios followed by randomized freeze/redirect/latency traffic,
// checked against a program-order model of the instruction stream IF/ID must observe.
module tb_if_fetch_unit;

    logic        clk;
    logic        rstn;
    logic        freeze;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] pc_o;
    logic [31:0] instr_o;
    logic        flush_o;

    if_fetch_unit_if #(.N(32)) bus ();

    if_fetch_unit #(
        .N        (32),
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (4)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .freeze         (freeze),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (bus.master),
        .pc_o           (pc_o),
        .instr_o        (instr_o),
        .flush_o        (flush_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Responder state: at most one request tracked, answered after 1 + delay cycles.
    bit          pending   = 1'b0;
    logic [31:0] pend_addr = '0;
    int          delay     = 0;
    int          lat_fixed = 0;
    bit          rst_req   = 1'b1;

    // Reference model: next address that must be requested and next PC that must be consumed.
    logic [31:0] fetch_ptr = '0;
    logic [31:0] exp_pc    = '0;
    int          consumed  = 0;

    logic        o_req;
    logic [31:0] o_addr;
    logic [31:0] o_pc;
    logic [31:0] o_instr;
    logic        o_flush;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0000_0013;
            32'h0000_0004: return 32'h0000_0093;
            32'h0000_0008: return 32'h0000_0ABC;
            default:       return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, sample after settling, check and advance the model.
    task automatic cycle(input bit frz, input bit rdr, input logic [31:0] rpc);
        bit busy;
        @(negedge clk);
        rstn = !rst_req;
        busy = pending;
        if (pending && delay == 0) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = imem_word(pend_addr);
            pending         = 1'b0;
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = $urandom;
            if (pending) delay--;
        end
        freeze         = frz;
        redirect_valid = rdr;
        redirect_pc    = rpc;
        #1;
        o_req   = bus.imem_req;
        o_addr  = bus.imem_addr;
        o_pc    = pc_o;
        o_instr = instr_o;
        o_flush = flush_o;
        if (rstn) begin
            if (rdr) chk("flush_on_redirect", {31'b0, o_flush}, 32'd1);
            if (o_req) begin
                chk("single_outstanding", {31'b0, busy}, 32'd0);
                chk("fetch_addr", o_addr, fetch_ptr);
                fetch_ptr = fetch_ptr + 32'd4;
                pending   = 1'b1;
                pend_addr = o_addr;
                delay     = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 2));
            end
            if (!o_flush && !frz && !rdr) begin
                chk("consume_pc", o_pc, exp_pc);
                chk("consume_instr", o_instr, imem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            if (rdr) begin
                fetch_ptr = rpc;
                exp_pc    = rpc;
            end
        end else begin
            chk("req_in_reset", {31'b0, o_req}, 32'd0);
            pending   = 1'b0;
            fetch_ptr = '0;
            exp_pc    = '0;
        end
    endtask

    task automatic wait_req(input int max_cycles, input string tag, input logic [31:0] exp_addr);
        bit seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            cycle(1'b0, 1'b0, '0);
            seen = o_req;
        end
        chk({tag, "_seen"}, {31'b0, seen}, 32'd1);
        chk({tag, "_addr"}, o_addr, exp_addr);
    endtask

    initial begin
        int consumed_before;
        bit frz;
        bit rdr;
        logic [31:0] rpc;

        rstn            = 1'b0;
        freeze          = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;

        // Reset for two edges; outputs must be in their reset state after the first.
        rst_req = 1'b1;
        cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, '0);
        chk("rst_flush", {31'b0, o_flush}, 32'd1);
        chk("rst_pc", o_pc, 32'h0);
        chk("rst_instr", o_instr, 32'h0);
        rst_req = 1'b0;

        // Stream with a 1-cycle memory.
        lat_fixed = 0;
        cycle(1'b0, 1'b0, '0);
        chk("c1_req", {31'b0, o_req}, 32'd1);
        chk("c1_addr", o_addr, 32'h0);
        chk("c1_flush", {31'b0, o_flush}, 32'd1);
        chk("c1_pc", o_pc, 32'h0);
        chk("c1_instr", o_instr, 32'h0);
        cycle(1'b0, 1'b0, '0);
        chk("c2_flush", {31'b0, o_flush}, 32'd1);
        cycle(1'b0, 1'b0, '0);
        chk("c3_flush", {31'b0, o_flush}, 32'd0);
        chk("c3_instr", o_instr, 32'h13);
        cycle(1'b0, 1'b0, '0);
        chk("c4_bubble", {31'b0, o_flush}, 32'd1);

        // Freeze with buffer full while 0xABC returns: skid, no request, output held.
        cycle(1'b1, 1'b0, '0);
        chk("c5_instr", o_instr, 32'h93);
        chk("c5_pc", o_pc, 32'h4);
        cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, '0);
        chk("full_no_req", {31'b0, o_req}, 32'd0);
        chk("full_hold", o_instr, 32'h93);
        cycle(1'b0, 1'b0, '0);
        chk("unfreeze_req", {31'b0, o_req}, 32'd0);
        lat_fixed = 2;
        cycle(1'b0, 1'b0, '0);
        chk("skid_instr", o_instr, 32'hABC);
        chk("skid_pc", o_pc, 32'h8);

        // Redirect in WAIT before the response: the late word is drained and discarded.
        cycle(1'b0, 1'b1, 32'h100);
        chk("drop_req0", {31'b0, o_req}, 32'd0);
        cycle(1'b0, 1'b0, '0);
        chk("drop_req1", {31'b0, o_req}, 32'd0);
        cycle(1'b0, 1'b0, '0);
        chk("drop_rvalid_flush", {31'b0, o_flush}, 32'd1);
        chk("drop_req2", {31'b0, o_req}, 32'd0);
        lat_fixed = 1;
        cycle(1'b0, 1'b0, '0);
        chk("after_drop_req", {31'b0, o_req}, 32'd1);
        chk("after_drop_addr", o_addr, 32'h100);

        // Redirect coinciding with the response.
        cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, 32'h300);
        chk("same_cycle_flush", {31'b0, o_flush}, 32'd1);
        cycle(1'b0, 1'b0, '0);
        chk("same_cycle_req", {31'b0, o_req}, 32'd1);
        chk("same_cycle_addr", o_addr, 32'h300);

        // Wrap of the PC past the top of the address space.
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC);
        lat_fixed = 0;
        wait_req(10, "wrap_top", 32'hFFFF_FFFC);
        wait_req(10, "wrap_zero", 32'h0000_0000);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0);

        // Randomized traffic with one reset in the middle.
        lat_fixed       = -1;
        consumed_before = consumed;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                rst_req = 1'b1;
                cycle(1'b0, 1'b0, '0);
                cycle(1'b0, 1'b0, '0);
                rst_req = 1'b0;
            end
            frz = ($urandom_range(0, 99) < 35);
            rdr = !frz && ($urandom_range(0, 99) < 5);
            if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
            else                           rpc = $urandom & 32'hFFFF_FFFC;
            cycle(frz, rdr, rpc);
        end
        chk("random_progress", {31'b0, (consumed - consumed_before) > 200}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
